// File: rtl/dma_fp_responder.sv
// CPU-side responder for the external DMA / front-panel write bus.
// Define DMA_TIMEOUT_EN to add the idle-grant timeout and the dma_timeout port.
module dma_fp_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 8,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_req,
  output logic              dma_ack,
  input  logic [ADDR_W-1:0] fp_bus_addr,
  input  logic [DATA_W-1:0] fp_bus_data,
  input  logic              fp_write,
  input  logic              cpu_busy,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_wait,
  output logic              dma_active,
  output logic              dma_overrun,
`ifdef DMA_TIMEOUT_EN
  output logic              dma_timeout,
`endif
  output logic [CNT_W-1:0]  dma_write_count
);

  typedef enum logic [2:0] {IDLE, HOLD, GRANT, WRITE, RELEASE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic                   wr_prev;
  logic [ADDR_W-1:0]      cap_addr;
  logic [DATA_W-1:0]      cap_data;
  logic [ADDR_W-1:0]      pend_addr;
  logic [DATA_W-1:0]      pend_data;
  logic                   pend_valid;
  logic                   hold_settled;
  logic                   req_s;
  logic                   wr_edge;
`ifdef DMA_TIMEOUT_EN
  logic [31:0]            idle_cnt;
  logic                   forced;
`endif

  assign req_s   = req_sync[SYNC_STAGES-1];
  assign wr_edge = wr_sync[SYNC_STAGES-1] & ~wr_prev;

  // Address/data are captured as soon as the strobe reaches the first flop,
  // while the master still guarantees them stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_sync <= '0;
      wr_sync  <= '0;
      wr_prev  <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], dma_req};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], fp_write};
      wr_prev  <= wr_sync[SYNC_STAGES-1];
      if (fp_write && !wr_sync[0]) begin
        cap_addr <= fp_bus_addr;
        cap_data <= fp_bus_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      dma_ack         <= 1'b0;
      cpu_hold        <= 1'b0;
      dma_active      <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      dma_overrun     <= 1'b0;
      dma_write_count <= '0;
      pend_addr       <= '0;
      pend_data       <= '0;
      pend_valid      <= 1'b0;
      hold_settled    <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      idle_cnt        <= '0;
      forced          <= 1'b0;
      dma_timeout     <= 1'b0;
`endif
    end else begin
`ifdef DMA_TIMEOUT_EN
      dma_timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (req_s) begin
            state        <= HOLD;
            cpu_hold     <= 1'b1;
            hold_settled <= 1'b0;
          end
        end
        // cpu_busy is trusted only after the CPU has seen cpu_hold for a cycle.
        HOLD: begin
          if (!req_s) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end else if (hold_settled && !cpu_busy) begin
            state           <= GRANT;
            dma_ack         <= 1'b1;
            dma_active      <= 1'b1;
            dma_write_count <= '0;
            dma_overrun     <= 1'b0;
            pend_valid      <= 1'b0;
`ifdef DMA_TIMEOUT_EN
            idle_cnt        <= '0;
`endif
          end else begin
            hold_settled <= 1'b1;
          end
        end
        GRANT: begin
          if (pend_valid || wr_edge) begin
            state  <= WRITE;
            mem_we <= 1'b1;
`ifdef DMA_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (pend_valid) begin
              mem_addr  <= pend_addr;
              mem_wdata <= pend_data;
              if (wr_edge) begin
                pend_addr <= cap_addr;
                pend_data <= cap_data;
              end else begin
                pend_valid <= 1'b0;
              end
            end else begin
              mem_addr  <= cap_addr;
              mem_wdata <= cap_data;
            end
          end else if (!req_s) begin
            state      <= RELEASE;
            dma_ack    <= 1'b0;
            dma_active <= 1'b0;
            cpu_hold   <= 1'b0;
`ifdef DMA_TIMEOUT_EN
          end else if (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            state       <= RELEASE;
            dma_ack     <= 1'b0;
            dma_active  <= 1'b0;
            cpu_hold    <= 1'b0;
            forced      <= 1'b1;
            dma_timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1;
`endif
          end
        end
        // A strobe arriving mid-write parks in the single pending slot.
        WRITE: begin
          if (wr_edge) begin
            if (!pend_valid) begin
              pend_valid <= 1'b1;
              pend_addr  <= cap_addr;
              pend_data  <= cap_data;
            end else begin
              dma_overrun <= 1'b1;
            end
          end
          if (!mem_wait) begin
            state  <= GRANT;
            mem_we <= 1'b0;
            if (dma_write_count != '1)
              dma_write_count <= dma_write_count + 1'b1;
          end
        end
        RELEASE: begin
`ifdef DMA_TIMEOUT_EN
          if (!forced || !req_s) begin
            state  <= IDLE;
            forced <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dma_fp_responder.md
Name: dma_fp_responder

Overview:
- CPU-side responder for the external DMA / front-panel bus protocol.
- An external master raises dma_req, waits for dma_ack, then issues byte writes by presenting fp_bus_addr/fp_bus_data and pulsing fp_write.
- This block synchronizes the request, holds the CPU off the memory bus at a safe boundary, grants dma_ack, and converts each fp_write strobe into one memory write cycle.
- It sits between the external DMA connector and the memory bus mux, alongside the CPU bus controller.

Parameters:
- SYNC_STAGES, 2, flops in each async-input synchronizer (dma_req, fp_write); minimum 2.
- ADDR_W, 24, memory/front-panel address width.
- DATA_W, 8, data width.
- CNT_W, 16, width of the per-grant write counter.
- TIMEOUT_CYCLES, 65535, idle-grant timeout; used only with DMA_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dma_req  in  1  async DMA request from the external master.
- dma_ack  out  1  grant; the master may drive fp_* only while this is high.
- fp_bus_addr  in  ADDR_W  write address from the master.
- fp_bus_data  in  DATA_W  write data from the master.
- fp_write  in  1  async write strobe; the rising edge marks one write.
- cpu_busy  in  1  CPU is mid bus cycle.
- cpu_hold  out  1  stalls the CPU at its next bus boundary.
- mem_addr  out  ADDR_W  memory address during DMA.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_wait  in  1  memory not ready; extends the write.
- dma_active  out  1  memory bus mux select (1 = DMA owns the bus).
- dma_overrun  out  1  sticky: a strobe was lost.
- dma_write_count  out  CNT_W  completed writes in the current or last grant.

Behaviour:
Reset:
- All outputs are 0, the FSM is in IDLE, synchronizers and capture registers are cleared.
- A reset asserted mid-operation drops dma_ack, mem_we, cpu_hold and dma_active on the next clock. No partial write completes.

Synchronization:
- dma_req and fp_write each pass through SYNC_STAGES flops; logic uses only the last stage.
- A fp_write edge is detected as last stage = 1 and previous = 0.
- fp_bus_addr/fp_bus_data are latched on the clock where the first fp_write sync stage first reads 1.
- The master must hold addr/data stable from at least 1 clk before the strobe until the strobe falls.
- The latched value is held in a capture register (cap) until it is consumed.

FSM states:
- IDLE: sync dma_req = 1 → HOLD.
- HOLD: cpu_hold = 1. When cpu_busy = 0 → GRANT. If dma_req drops while in HOLD → IDLE; cpu_hold clears and dma_ack never asserts.
- GRANT:
  - cpu_hold = 1, dma_active = 1, dma_ack = 1.
  - dma_write_count clears on entry from HOLD.
  - A write edge or a pending entry → WRITE.
  - Otherwise, sync dma_req = 0 → RELEASE.
- WRITE:
  - mem_addr/mem_wdata come from cap (or pending); mem_we = 1.
  - Stays in WRITE while mem_wait = 1.
  - Completes on the first cycle with mem_wait = 0: count += 1 (saturating at all-ones), then → GRANT.
- RELEASE: dma_ack = 0, mem_we = 0, dma_active = 0, cpu_hold = 0 for exactly one cycle → IDLE.

Latency: the dma_ack rising edge occurs 1 clk after entering GRANT is decided, i.e. SYNC_STAGES + 2 clks after dma_req is seen by the first sync stage, given cpu_busy = 0.

Boundary conditions:
- A strobe edge during WRITE goes into a 1-deep pending slot, which is written immediately after the current write.
- A strobe edge while pending is already full is dropped and sets dma_overrun. dma_overrun clears only on reset or on entry to GRANT from HOLD.
- A dma_req fall during WRITE: the current write and any pending write finish, then RELEASE.
- A strobe edge in the same cycle as a dma_req fall in GRANT: the write wins, and release follows afterwards.
- A strobe while not in GRANT/WRITE is ignored and does not set overrun.
- mem_addr/mem_wdata hold their last values when idle. dma_write_count holds until the next grant.

Optional Feature:
- Macro: DMA_TIMEOUT_EN.
- Defined:
  - An idle counter runs in GRANT and resets on every write edge.
  - Reaching TIMEOUT_CYCLES forces RELEASE, even with dma_req still high.
  - The block then waits for sync dma_req = 0 before returning to IDLE.
  - An extra output port dma_timeout is a 1-cycle pulse on forced release.
- Undefined: no counter and no dma_timeout port; a grant lasts as long as dma_req is held.

Test Plan:
- Basic grant: raise dma_req with cpu_busy = 0 → dma_ack = 1 after SYNC_STAGES + 2 clks, cpu_hold = 1, dma_active = 1. Drop dma_req → one RELEASE cycle, then all outputs 0.
- Two writes: addr 0x100040 data 0x00, then 0x100041 data 0x00, strobes 3 clks wide → two mem_we pulses with matching addr/data; dma_write_count = 2; dma_overrun = 0.
- CPU busy: hold cpu_busy = 1 for 10 clks after the request → dma_ack stays low throughout, rises 1 clk after cpu_busy falls. Drop dma_req mid-HOLD → no ack, back to IDLE.
- mem_wait stretch and back-to-back strobes:
  - Hold mem_wait = 1 for 8 clks during the first write and send 2 more strobes.
  - Required: the second write fills pending and is written after the first; the third is dropped; dma_overrun = 1; count = 2.
- Reset and request-drop corners:
  - Assert reset during WRITE → mem_we, dma_ack and cpu_hold are 0 next clk; count = 0.
  - Drop dma_req during WRITE → that write completes before RELEASE.
- DMA_TIMEOUT_EN with TIMEOUT_CYCLES = 100: grant with no strobes → forced RELEASE at 100 clks, dma_timeout pulses once, and no new grant occurs until dma_req is low.
